id_stage: RTL and testbench

- Registered, parametrised RV32I instruction-decode stage that replaces the combinational decoder in the IF→ID→EX path.
- Decodes the instruction, presents register addresses to the register file, and selects the operands.
- Registers the full decode bundle into a 2-entry skid buffer with a valid/ready handshake on both sides.
- Adds pipeline flush, illegal-instruction flagging, and a load-use hazard stall with a configurable load latency.

---
 rtl/id_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : registered RV32I instruction-decode stage.
//
// Decodes the incoming instruction and selects ALU operands from the register
// file read data. The resulting bundle is held in an output register, backed by
// one skid entry, with a valid/ready handshake on both sides. It also provides
// pipeline flush, illegal-instruction flagging and a load-use hazard stall.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  upstream handshake (in_ready_o high iff skid empty)
//   inst_i, inst_addr_i      instruction word and its PC
//   rs1_addr_o, rs2_addr_o   register-file read addresses (combinational)
//   op1_i, op2_i             register-file read data, same cycle
//   flush_i                  discard every held entry
//   out_valid_o / out_ready_i downstream handshake
//   inst_o .. illegal_o      registered decode bundle
//
// Parameters
//   XLEN      data/address width
//   RADDR_W   register address width
//   LOAD_LAT  cycles a dependent instruction is held after a load leaves
//             (0 disables the stall, maximum 7)
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  output logic [RADDR_W-1:0] rs1_addr_o,
  output logic [RADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_addr_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               wen_o,
  output logic               ram_en_o,
  output logic               ram_rw_o,
  output logic               J_o,
  output logic               flag_t_o,
  output logic [3:0]         oprt_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [XLEN-1:0]    ram_indata_o,
  output logic               illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);

  typedef struct packed {
    logic [31:0]        inst;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rd;
    logic               wen;
    logic               ram_en;
    logic               ram_rw;
    logic               j;
    logic               flag_t;
    logic [3:0]         oprt;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    indata;
    logic               illegal;
  } bundle_t;

  // A bundle is a load when it accesses memory without writing it; illegal
  // instructions never set ram_en, so only real LOADs qualify.
  function automatic logic is_load(input bundle_t b);
    return b.ram_en && !b.ram_rw;
  endfunction

  // True when a load writing rd feeds a source register the incoming
  // instruction actually reads.
  function automatic logic rd_hits(input logic [RADDR_W-1:0] rd,
                                   input logic               u1,
                                   input logic               u2,
                                   input logic [RADDR_W-1:0] a,
                                   input logic [RADDR_W-1:0] b);
    return (rd != '0) && ((u1 && (rd == a)) || (u2 && (rd == b)));
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               f7b5;
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    imm_s;
  logic [XLEN-1:0]    imm_u;
  logic               use_rs1;
  logic               use_rs2;
  bundle_t            dec;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign f7b5   = inst_i[30];
  assign rs1    = RADDR_W'(inst_i[19:15]);
  assign rs2    = RADDR_W'(inst_i[24:20]);
  assign rd     = RADDR_W'(inst_i[11:7]);

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  always_comb begin
    dec         = '0;
    dec.inst    = inst_i;
    dec.pc      = inst_addr_i;
    dec.rd      = rd;
    dec.indata  = op2_i;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        dec.op2 = imm_u;
        dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1 = inst_addr_i;
        dec.op2 = imm_u;
        dec.wen = 1'b1;
      end
      OPC_OP: begin
        dec.op1  = op1_i;
        dec.op2  = op2_i;
        dec.wen  = 1'b1;
        dec.oprt = {f7b5, funct3};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OPC_OPIMM: begin
        dec.op1  = op1_i;
        dec.op2  = imm_i;
        dec.wen  = 1'b1;
        // Only shift-right immediates use funct7[5] (SRLI vs SRAI); for the
        // rest those bits are immediate data.
        dec.oprt = {(funct3 == 3'b101) && f7b5, funct3};
        use_rs1  = 1'b1;
      end
      OPC_LOAD: begin
        dec.op1    = op1_i;
        dec.op2    = imm_i;
        dec.ram_en = 1'b1;
        dec.wen    = 1'b1;
        use_rs1    = 1'b1;
      end
      OPC_STORE: begin
        dec.op1    = op1_i;
        dec.op2    = imm_s;
        dec.ram_en = 1'b1;
        dec.ram_rw = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.op1    = op1_i;
        dec.op2    = op2_i;
        dec.flag_t = 1'b1;
        dec.oprt   = {1'b0, funct3};
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OPC_JAL: begin
        dec.op1 = inst_addr_i;
        dec.op2 = XLEN'(4);
        dec.j   = 1'b1;
        dec.wen = 1'b1;
      end
      OPC_JALR: begin
        // Link address is computed here; the target (rs1 + imm) is resolved
        // downstream from inst_o, so rs1 is still read for hazard purposes.
        dec.op1 = inst_addr_i;
        dec.op2 = XLEN'(4);
        dec.j   = 1'b1;
        dec.wen = 1'b1;
        use_rs1 = 1'b1;
      end
      default: begin
        // Covers inst[1:0] != 2'b11 as well, since every valid opcode ends 11.
        dec.illegal = 1'b1;
      end
    endcase
    if (rd == '0) begin
      dec.wen = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, skid entry and load-use tracking
  // ---------------------------------------------------------------------------
  bundle_t            out_reg;
  bundle_t            skid_reg;
  logic               out_valid_reg;
  logic               skid_valid_reg;
  logic [2:0]         cnt_reg;
  logic [RADDR_W-1:0] last_rd_reg;
  logic               hazard;
  logic               accept;
  logic               drain;

  always_comb begin
    hazard = 1'b0;
    if (LOAD_LAT != 0) begin
      if (out_valid_reg && is_load(out_reg) &&
          rd_hits(out_reg.rd, use_rs1, use_rs2, rs1, rs2)) begin
        hazard = 1'b1;
      end
      if (skid_valid_reg && is_load(skid_reg) &&
          rd_hits(skid_reg.rd, use_rs1, use_rs2, rs1, rs2)) begin
        hazard = 1'b1;
      end
      if ((cnt_reg != 3'd0) &&
          rd_hits(last_rd_reg, use_rs1, use_rs2, rs1, rs2)) begin
        hazard = 1'b1;
      end
    end
  end

  // in_ready_o stays a pure register output; the stall and flush only gate
  // whether the offered instruction is taken.
  assign in_ready_o = ~skid_valid_reg;
  assign accept     = in_valid_i && in_ready_o && !hazard && !flush_i;
  assign drain      = out_valid_reg && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      cnt_reg        <= 3'd0;
      last_rd_reg    <= '0;
    end else if (flush_i) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      cnt_reg        <= 3'd0;
    end else begin
      if (drain) begin
        // A full skid blocks accept, so skid refill and direct load of the
        // output register are mutually exclusive here.
        if (skid_valid_reg) begin
          out_reg        <= skid_reg;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_reg <= dec;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        if (out_valid_reg) begin
          skid_reg       <= dec;
          skid_valid_reg <= 1'b1;
        end else begin
          out_reg       <= dec;
          out_valid_reg <= 1'b1;
        end
      end

      if (drain && is_load(out_reg)) begin
        cnt_reg     <= LAT_INIT;
        last_rd_reg <= out_reg.rd;
      end else if (cnt_reg != 3'd0) begin
        cnt_reg <= cnt_reg - 3'd1;
      end
    end
  end

  assign out_valid_o  = out_valid_reg;
  assign inst_o       = out_reg.inst;
  assign inst_addr_o  = out_reg.pc;
  assign rd_addr_o    = out_reg.rd;
  assign wen_o        = out_reg.wen;
  assign ram_en_o     = out_reg.ram_en;
  assign ram_rw_o     = out_reg.ram_rw;
  assign J_o          = out_reg.j;
  assign flag_t_o     = out_reg.flag_t;
  assign oprt_o       = out_reg.oprt;
  assign op1_o        = out_reg.op1;
  assign op2_o        = out_reg.op2;
  assign ram_indata_o = out_reg.indata;
  assign illegal_o    = out_reg.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage.
// Directed steps followed by random traffic, all compared every cycle against
// a queue-based reference model of the held entries.
// -----------------------------------------------------------------------------
module tb_id_stage;

  localparam int LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [4:0]  rd_addr_o;
  logic        wen_o;
  logic        ram_en_o;
  logic        ram_rw_o;
  logic        J_o;
  logic        flag_t_o;
  logic [3:0]  oprt_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] ram_indata_o;
  logic        illegal_o;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .RADDR_W(5), .LOAD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .rd_addr_o(rd_addr_o),
    .wen_o(wen_o), .ram_en_o(ram_en_o), .ram_rw_o(ram_rw_o),
    .J_o(J_o), .flag_t_o(flag_t_o), .oprt_o(oprt_o),
    .op1_o(op1_o), .op2_o(op2_o), .ram_indata_o(ram_indata_o),
    .illegal_o(illegal_o)
  );

  // ---------------------------------------------------------------- model ---
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        ram_en;
    logic        ram_rw;
    logic        j;
    logic        flag_t;
    logic [3:0]  oprt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] indata;
    logic        illegal;
  } exp_t;

  exp_t        held[$];      // entries inside the stage, oldest first
  int          lat_left;     // cycles of stall left after the last load left
  logic [4:0]  last_load_rd;

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] s;
    logic [2:0] f3;
    f3 = inst[14:12];
    e.inst = inst; e.pc = pc; e.rd = inst[11:7];
    e.wen = 0; e.ram_en = 0; e.ram_rw = 0; e.j = 0; e.flag_t = 0;
    e.oprt = 4'd0; e.op1 = 32'd0; e.op2 = 32'd0; e.indata = b; e.illegal = 0;
    case (inst[6:0])
      7'h37: begin e.op2 = {inst[31:12], 12'h000}; e.wen = 1; end
      7'h17: begin e.op1 = pc; e.op2 = {inst[31:12], 12'h000}; e.wen = 1; end
      7'h33: begin e.op1 = a; e.op2 = b; e.wen = 1; e.oprt = {inst[30], f3}; end
      7'h13: begin
        e.op1 = a; s = inst; s = s >>> 20; e.op2 = s; e.wen = 1;
        e.oprt = {(f3 == 3'd5) ? inst[30] : 1'b0, f3};
      end
      7'h03: begin e.op1 = a; s = inst; s = s >>> 20; e.op2 = s; e.ram_en = 1; e.wen = 1; end
      7'h23: begin
        e.op1 = a; s = inst; s = s >>> 25; e.op2 = s;
        e.op2 = (e.op2 << 5) | {27'd0, inst[11:7]};
        e.ram_en = 1; e.ram_rw = 1;
      end
      7'h63: begin e.op1 = a; e.op2 = b; e.flag_t = 1; e.oprt = {1'b0, f3}; end
      7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; e.j = 1; e.wen = 1; end
      default: e.illegal = 1;
    endcase
    if (e.rd == 5'd0) e.wen = 0;
    return e;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc);
    return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return opc inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic depends(input logic [31:0] inst, input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((reads_rs1(inst[6:0]) && inst[19:15] == rd) ||
            (reads_rs2(inst[6:0]) && inst[24:20] == rd));
  endfunction

  function automatic logic model_hazard(input logic [31:0] inst);
    if (LAT == 0) return 1'b0;
    foreach (held[k]) begin
      if (held[k].inst[6:0] == 7'h03 && depends(inst, held[k].rd)) return 1'b1;
    end
    if (lat_left > 0 && depends(inst, last_load_rd)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [174:0] pack_exp(input exp_t e);
    return {e.inst, e.pc, e.rd, e.wen, e.ram_en, e.ram_rw, e.j, e.flag_t,
            e.oprt, e.op1, e.op2, e.indata, e.illegal};
  endfunction

  function automatic logic [174:0] dut_bundle();
    return {inst_o, inst_addr_o, rd_addr_o, wen_o, ram_en_o, ram_rw_o, J_o,
            flag_t_o, oprt_o, op1_o, op2_o, ram_indata_o, illegal_o};
  endfunction

  task automatic chk(input string tag, input logic [174:0] obs, input logic [174:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, then advance
  // the model across the rising edge.
  task automatic step(input logic vin, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic ordy);
    logic acc;
    logic drn;
    exp_t e;
    in_valid_i = vin; inst_i = inst; inst_addr_i = pc;
    op1_i = a; op2_i = b; flush_i = fl; out_ready_i = ordy;
    @(negedge clk);
    chk("in_ready", in_ready_o, held.size() < 2);
    chk("out_valid", out_valid_o, held.size() > 0);
    chk("rs1_addr", rs1_addr_o, inst[19:15]);
    chk("rs2_addr", rs2_addr_o, inst[24:20]);
    if (held.size() > 0) chk("bundle", dut_bundle(), pack_exp(held[0]));
    acc = vin && (held.size() < 2) && !fl && !model_hazard(inst);
    drn = (held.size() > 0) && ordy;
    e   = ref_decode(inst, pc, a, b);
    @(posedge clk);
    if (fl) begin
      held.delete();
      lat_left = 0;
    end else begin
      if (lat_left > 0) lat_left--;
      if (drn) begin
        if (held[0].inst[6:0] == 7'h03) begin
          lat_left     = LAT;
          last_load_rd = held[0].rd;
        end
        void'(held.pop_front());
      end
      if (acc) held.push_back(e);
    end
    $display("step vin=%0b inst=%08h fl=%0b ordy=%0b acc=%0b held=%0d", vin, inst, fl, ordy, acc, held.size());
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  // Offer a load, then the consumer until it shows on the outputs; n is the
  // number of cycles the consumer was offered.
  task automatic load_use(input logic [31:0] ld, input logic [31:0] use_inst, output int n);
    idle(LAT + 3);
    step(1'b1, ld, 32'h100, $urandom, $urandom, 1'b0, 1'b1);
    n = 0;
    do begin
      step(1'b1, use_inst, 32'h104, $urandom, $urandom, 1'b0, 1'b1);
      n++;
    end while (!(out_valid_o && inst_o == use_inst) && n < 20);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h13;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      default: w[1:0] = 2'($urandom_range(0, 2));
    endcase
    // Small register range so dependencies on recent loads are common.
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // ----------------------------------------------------------- stimulus ---
  localparam logic [31:0] I_A = 32'h00100093;  // ADDI x1,x0,1
  localparam logic [31:0] I_B = 32'h00200113;  // ADDI x2,x0,2
  localparam logic [31:0] I_C = 32'h00300193;  // ADDI x3,x0,3

  initial begin
    int n;
    checks = 0; errors = 0;
    lat_left = 0; last_load_rd = 5'd0;
    rst_n = 1'b0; in_valid_i = 0; inst_i = 0; inst_addr_i = 0;
    op1_i = 0; op2_i = 0; flush_i = 0; out_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_bundle", dut_bundle(), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI x1,x0,5
    step(1'b1, 32'h00500093, 32'h0, 32'h0, $urandom, 1'b0, 1'b1);
    chk("addi_valid", out_valid_o, 1'b1);
    chk("addi_rd", rd_addr_o, 5'd1);
    chk("addi_wen", wen_o, 1'b1);
    chk("addi_op1", op1_o, 32'd0);
    chk("addi_op2", op2_o, 32'd5);
    chk("addi_oprt", oprt_o, 4'd0);

    // Illegal encoding (inst[1:0] = 01)
    step(1'b1, 32'h00042081, 32'h4, $urandom, $urandom, 1'b0, 1'b1);
    chk("ill_flag", illegal_o, 1'b1);
    chk("ill_wen", wen_o, 1'b0);
    chk("ill_ram_en", ram_en_o, 1'b0);
    chk("ill_valid", out_valid_o, 1'b1);
    idle(2);

    // Back-pressure: three pushes, two accepted, ordered drain
    step(1'b1, I_A, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_ready1", in_ready_o, 1'b1);
    step(1'b1, I_B, 32'h14, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_ready2", in_ready_o, 1'b0);
    step(1'b1, I_C, 32'h18, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_hold_inst", inst_o, I_A);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_hold_op2", op2_o, 32'd1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("bp_drain_b", inst_o, I_B);
    chk("bp_ready_back", in_ready_o, 1'b1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("bp_c_dropped", out_valid_o, 1'b0);

    // Load-use: consumer held 1 cycle while the load sits in the stage plus
    // LAT cycles after it leaves; independent or x0 pairs go straight through.
    load_use(32'h00012283, 32'h00128333, n);  // LW x5,0(x2) ; ADD x6,x5,x1
    chk("lu_dep_cycles", n, 2 + LAT);
    load_use(32'h00012283, 32'h00100333, n);  // LW x5 ; ADD x6,x0,x1
    chk("lu_indep_cycles", n, 1);
    load_use(32'h00012003, 32'h00100333, n);  // LW x0 ; ADD x6,x0,x1
    chk("lu_x0_cycles", n, 1);

    // Flush with both entries full and an instruction offered
    idle(LAT + 2);
    step(1'b1, I_A, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, I_B, 32'h24, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, I_C, 32'h28, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fl_out_valid", out_valid_o, 1'b0);
    chk("fl_in_ready", in_ready_o, 1'b1);
    idle(3);
    chk("fl_dropped", out_valid_o, 1'b0);

    // SW x3,8(x4)
    step(1'b1, 32'h00322423, 32'h200, $urandom, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("sw_ram_en", ram_en_o, 1'b1);
    chk("sw_ram_rw", ram_rw_o, 1'b1);
    chk("sw_wen", wen_o, 1'b0);
    chk("sw_op2", op2_o, 32'd8);
    chk("sw_indata", ram_indata_o, 32'hDEADBEEF);

    // Random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        in_valid_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_in_ready", in_ready_o, 1'b1);
        held.delete();
        lat_left = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      step($urandom_range(0, 3) != 0, gen_inst(), $urandom, $urandom, $urandom,
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
